ibuf_flow_ctrl: RTL and testbench

//  Pointer/occupancy controller for the 32-entry circular instruction buffer between fetch and decode.
//  - Accepts 8-wide fetch bundles with a valid mask.
//  - Issues up to 4 instructions per cycle to decode.
//  - Raises fetch stall when the buffer cannot take a whole bundle.
//  - Sequences flush recovery through a small FSM.
//  - Drives the buffer storage's write/read addresses; holds no instruction data.

---
 rtl/ibuf_flow_ctrl_pkg.sv | 33 +++
 rtl/ibuf_popcnt8.sv | 13 +
 rtl/ibuf_flow_ctrl.sv | 105 ++++++++++
 tb/tb_ibuf_flow_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ibuf_flow_ctrl_pkg.sv
// Shared constants for the instruction-buffer flow controller: geometry,
// field widths, FSM encodings and the occupancy-to-state mapping.
package ibuf_flow_ctrl_pkg;

  localparam int IBUF_DEPTH     = 32;
  localparam int IBUF_BUNDLE    = 8;
  localparam int IBUF_ISSUE_W   = 4;
  localparam int IBUF_FLUSH_CYC = 2;

  localparam int PTR_W  = 5;
  localparam int CNT_W  = 6;
  localparam int WCNT_W = 4;
  localparam int ICNT_W = 3;
  localparam int TMR_W  = 2;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  // FULL means a whole bundle no longer fits in the free space.
  function automatic logic [1:0] occ_state(input logic [CNT_W-1:0] cnt);
    logic [1:0] st;
    if (cnt == '0)
      st = ST_EMPTY;
    else if ((CNT_W'(IBUF_DEPTH) - cnt) < CNT_W'(IBUF_BUNDLE))
      st = ST_FULL;
    else
      st = ST_RUN;
    return st;
  endfunction

endpackage

// File: rtl/ibuf_popcnt8.sv
// Combinational population count of an 8-slot fetch valid mask.
module ibuf_popcnt8 (
  input  logic [7:0] mask_i,
  output logic [3:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 8; i++)
      cnt_o = cnt_o + {3'b000, mask_i[i]};
  end

endmodule

// File: rtl/ibuf_flow_ctrl.sv
// Pointer/occupancy controller for the circular instruction buffer between
// fetch and decode; produces storage addresses, issue counts and fetch stall.
module ibuf_flow_ctrl
  import ibuf_flow_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              fetch_vld_i,
  input  logic [7:0]        fetch_mask_i,
  input  logic              decode_rdy_i,
  output logic              wr_en_o,
  output logic [PTR_W-1:0]  wr_ptr_o,
  output logic [WCNT_W-1:0] wr_cnt_o,
  output logic [PTR_W-1:0]  rd_ptr_o,
  output logic [ICNT_W-1:0] issue_cnt_o,
  output logic              issue_vld_o,
  output logic              fetch_stall_o,
  output logic [CNT_W-1:0]  buf_cnt_o,
  output logic              buf_empty_o,
  output logic              buf_full_o,
  output logic [1:0]        state_o
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [WCNT_W-1:0] pop_cnt;
  logic [ICNT_W-1:0] avail_cnt;
  logic              accept;
  logic              can_issue;

  ibuf_popcnt8 u_popcnt (
    .mask_i (fetch_mask_i),
    .cnt_o  (pop_cnt)
  );

  always_comb begin
    fetch_stall_o = (state_q == ST_FULL) | (state_q == ST_FLUSH);
    accept        = fetch_vld_i & ~fetch_stall_o & ~flush_i;
    wr_cnt_o      = accept ? pop_cnt : '0;
    wr_en_o       = accept & (fetch_mask_i != 8'h00);
    can_issue     = decode_rdy_i & ~flush_i &
                    ((state_q == ST_RUN) | (state_q == ST_FULL));
    avail_cnt     = (cnt_q >= CNT_W'(IBUF_ISSUE_W)) ? ICNT_W'(IBUF_ISSUE_W)
                                                    : cnt_q[ICNT_W-1:0];
    issue_cnt_o   = can_issue ? avail_cnt : '0;
    issue_vld_o   = issue_cnt_o != '0;
  end

  // Flush wins over everything; otherwise state follows next-cycle occupancy.
  always_comb begin
    cnt_d    = cnt_q + CNT_W'(wr_cnt_o) - CNT_W'(issue_cnt_o);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_cnt_o);
    rd_ptr_d = rd_ptr_q + PTR_W'(issue_cnt_o);
    tmr_d    = tmr_q;
    state_d  = state_q;
    if (flush_i) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      tmr_d    = TMR_W'(IBUF_FLUSH_CYC - 1);
      state_d  = ST_FLUSH;
    end else if (state_q == ST_FLUSH) begin
      if (tmr_q == '0)
        state_d = ST_EMPTY;
      else
        tmr_d = tmr_q - TMR_W'(1);
    end else begin
      state_d = occ_state(cnt_d);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tmr_q    <= tmr_d;
    end
  end

  // Fetch masks must be contiguous from slot 0; anything else is a fetch bug.
  always_ff @(posedge clock) begin
    if (!reset && fetch_vld_i)
      assert ((fetch_mask_i & (fetch_mask_i + 8'd1)) == 8'h00);
  end

  assign wr_ptr_o    = wr_ptr_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign buf_cnt_o   = cnt_q;
  assign buf_empty_o = cnt_q == '0;
  assign buf_full_o  = (CNT_W'(IBUF_DEPTH) - cnt_q) < CNT_W'(IBUF_BUNDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_ibuf_flow_ctrl.sv
// Directed and random stimulus for ibuf_flow_ctrl, compared every cycle
// against an occupancy/pointer reference model kept in plain integers.
module tb_ibuf_flow_ctrl;

  localparam int DEPTH     = 32;
  localparam int BUNDLE    = 8;
  localparam int ISSUE_W   = 4;
  localparam int FLUSH_CYC = 2;

  logic       clock;
  logic       reset;
  logic       flushIn;
  logic       vldIn;
  logic [7:0] maskIn;
  logic       rdyIn;
  logic       wrEn;
  logic [4:0] wrPtr;
  logic [3:0] wrCnt;
  logic [4:0] rdPtr;
  logic [2:0] issueCnt;
  logic       issueVld;
  logic       fetchStall;
  logic [5:0] bufCnt;
  logic       bufEmpty;
  logic       bufFull;
  logic [1:0] stateOut;

  int checks = 0;
  int errors = 0;

  int occ;
  int wp;
  int rp;
  int flushLeft;
  int expWc;
  int expIss;

  ibuf_flow_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .flush_i       (flushIn),
    .fetch_vld_i   (vldIn),
    .fetch_mask_i  (maskIn),
    .decode_rdy_i  (rdyIn),
    .wr_en_o       (wrEn),
    .wr_ptr_o      (wrPtr),
    .wr_cnt_o      (wrCnt),
    .rd_ptr_o      (rdPtr),
    .issue_cnt_o   (issueCnt),
    .issue_vld_o   (issueVld),
    .fetch_stall_o (fetchStall),
    .buf_cnt_o     (bufCnt),
    .buf_empty_o   (bufEmpty),
    .buf_full_o    (bufFull),
    .state_o       (stateOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int modelState();
    if (flushLeft > 0)               return 3;
    else if (occ == 0)               return 0;
    else if (DEPTH - occ < BUNDLE)   return 2;
    else                             return 1;
  endfunction

  task automatic modelReset();
    occ = 0;
    wp = 0;
    rp = 0;
    flushLeft = 0;
  endtask

  task automatic checkOutput();
    int  st;
    int  wc;
    int  iss;
    bit  stall;
    bit  acc;
    logic [4:0] ptrDiff;
    st    = modelState();
    stall = (st == 2) || (st == 3);
    acc   = vldIn && !stall && !flushIn;
    wc    = acc ? $countones(maskIn) : 0;
    iss   = (rdyIn && !flushIn && (st == 1 || st == 2)) ? ((occ < ISSUE_W) ? occ : ISSUE_W) : 0;
    check("state", 32'(stateOut), st);
    check("buf_cnt", 32'(bufCnt), occ);
    check("wr_ptr", 32'(wrPtr), wp);
    check("rd_ptr", 32'(rdPtr), rp);
    check("fetch_stall", 32'(fetchStall), 32'(stall));
    check("buf_empty", 32'(bufEmpty), 32'(occ == 0));
    check("buf_full", 32'(bufFull), 32'(DEPTH - occ < BUNDLE));
    check("wr_cnt", 32'(wrCnt), wc);
    check("wr_en", 32'(wrEn), 32'(wc != 0));
    check("issue_cnt", 32'(issueCnt), iss);
    check("issue_vld", 32'(issueVld), 32'(iss != 0));
    ptrDiff = wrPtr - rdPtr;
    check("ptr_invariant", 32'(ptrDiff), occ % DEPTH);
    expWc  = wc;
    expIss = iss;
  endtask

  task automatic applyStimulus(input bit f, input bit v, input logic [7:0] m, input bit r);
    @(negedge clock);
    flushIn = f;
    vldIn   = v;
    maskIn  = m;
    rdyIn   = r;
    #1;
    checkOutput();
    if (f) begin
      occ = 0;
      wp = 0;
      rp = 0;
      flushLeft = FLUSH_CYC;
    end else begin
      occ = occ + expWc - expIss;
      wp  = (wp + expWc) % DEPTH;
      rp  = (rp + expIss) % DEPTH;
      if (flushLeft > 0) flushLeft--;
    end
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  task automatic asyncReset();
    flushIn = 1'b0;
    vldIn   = 1'b0;
    maskIn  = 8'h00;
    rdyIn   = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput();
    check("reset_state", 32'(stateOut), 0);
    check("reset_empty", 32'(bufEmpty), 1);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int k;
    reset   = 1'b1;
    flushIn = 1'b0;
    vldIn   = 1'b0;
    maskIn  = 8'h00;
    rdyIn   = 1'b0;
    modelReset();
    #12;
    checkOutput();
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] single bundle, decode held off");
    applyStimulus(0, 1, 8'hFF, 0);
    settle();
    check("s1_cnt", 32'(bufCnt), 8);
    check("s1_state", 32'(stateOut), 1);

    $display("[TB] fill until a bundle no longer fits");
    applyStimulus(0, 1, 8'hFF, 0);
    applyStimulus(0, 1, 8'hFF, 0);
    settle();
    check("s2_cnt24", 32'(bufCnt), 24);
    applyStimulus(0, 1, 8'hFF, 0);
    settle();
    check("s2_cnt32", 32'(bufCnt), 32);
    check("s2_stall", 32'(fetchStall), 1);
    applyStimulus(0, 1, 8'hFF, 0);

    $display("[TB] drain four per cycle");
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 8'h00, 1);
    settle();
    check("s3_empty", 32'(stateOut), 0);

    $display("[TB] pointer wrap");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'hFF, 0);
    applyStimulus(0, 1, 8'h0F, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 8'h00, 1);
    settle();
    check("s4_rd28", 32'(rdPtr), 28);
    applyStimulus(0, 1, 8'hFF, 0);
    settle();
    check("s4_wr4", 32'(wrPtr), 4);
    applyStimulus(0, 0, 8'h00, 1);
    settle();
    check("s4_rd0", 32'(rdPtr), 0);
    applyStimulus(0, 0, 8'h00, 1);

    $display("[TB] partial bundles");
    applyStimulus(0, 1, 8'h07, 1);
    applyStimulus(0, 1, 8'h01, 1);
    applyStimulus(0, 0, 8'h00, 1);
    settle();
    check("s5_cnt0", 32'(bufCnt), 0);

    $display("[TB] flush with fetch and decode active");
    applyStimulus(0, 1, 8'hFF, 0);
    applyStimulus(0, 1, 8'h0F, 0);
    applyStimulus(1, 1, 8'hFF, 1);
    applyStimulus(0, 1, 8'hFF, 1);
    applyStimulus(0, 1, 8'hFF, 1);
    applyStimulus(0, 1, 8'hFF, 1);
    applyStimulus(0, 0, 8'h00, 1);

    $display("[TB] reset asserted during flush");
    applyStimulus(0, 1, 8'hFF, 0);
    applyStimulus(1, 0, 8'h00, 0);
    @(posedge clock);
    asyncReset();

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 8);
      applyStimulus(($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 7),
                    8'((1 << k) - 1), ($urandom_range(0, 1) == 1));
    end
    @(negedge clock);
    flushIn = 1'b0;
    vldIn   = 1'b0;
    rdyIn   = 1'b0;
    #1;
    checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
